// File: rtl/scalar_bus_pkg.sv
// Shared types and helpers for the scalar <-> bus bit packer/splitter pair.
// Both directions agree on bit placement through bit_pos().
package scalar_bus_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } packer_state_t;

  // Bus position of the idx-th serial bit.
  function automatic int bit_pos(input int idx, input int width, input bit lsb_first);
    return lsb_first ? idx : (width - 1 - idx);
  endfunction

endpackage

// File: rtl/scalar_to_bus_packer_if.sv
// Handshake bundle for the packer: scalar bit stream in, assembled bus word out.
// The slave modport is the packer's view; master is the surrounding source/sink.
interface scalar_to_bus_packer_if #(
  parameter int WIDTH = scalar_bus_pkg::DEFAULT_WIDTH
);
  localparam int CNT_W = $clog2(WIDTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic             in_bit;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_bus;
  logic [CNT_W-1:0] out_count;

  modport slave (
    input  in_valid, in_bit, in_last, out_ready,
    output in_ready, out_valid, out_bus, out_count
  );

  modport master (
    output in_valid, in_bit, in_last, out_ready,
    input  in_ready, out_valid, out_bus, out_count
  );

endinterface

// File: rtl/scalar_to_bus_packer.sv
// Collects single serial bits into a WIDTH-bit word, with early close on in_last
// (unwritten positions stay zero) and a count of the bits actually received.
//
// state | meaning
// ------+-----------------------------------------------------------------
// FILL  | accepting bits; each transfer writes one bus position
// HOLD  | word complete; out_bus/out_count frozen until the sink takes them
module scalar_to_bus_packer
  import scalar_bus_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  scalar_to_bus_packer_if.slave  bus
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int IDX_W = $clog2(WIDTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  packer_state_t    state;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] wr_pos;
  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] count_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic             in_xfer;
  logic             out_xfer;
  logic             word_done;

  assign wr_pos    = IDX_W'(bit_pos(int'(idx), WIDTH, LSB_FIRST));
  assign in_xfer   = bus.in_valid & in_ready_q;
  assign out_xfer  = out_valid_q & bus.out_ready;
  assign word_done = bus.in_last | (idx == LAST_IDX);

  // in_ready comes up on the first edge after reset release, not during reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= FILL;
      idx         <= '0;
      sreg        <= '0;
      count_q     <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        FILL: begin
          in_ready_q <= 1'b1;
          if (in_xfer) begin
            sreg[wr_pos] <= bus.in_bit;
            if (word_done) begin
              state       <= HOLD;
              count_q     <= CNT_W'(idx) + CNT_W'(1);
              in_ready_q  <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              idx <= idx + IDX_W'(1);
            end
          end
        end
        HOLD: begin
          // Clearing here is what makes early-closed words zero padded.
          if (out_xfer) begin
            state       <= FILL;
            idx         <= '0;
            sreg        <= '0;
            count_q     <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
          end
        end
        default: begin
          state       <= FILL;
          idx         <= '0;
          sreg        <= '0;
          count_q     <= '0;
          in_ready_q  <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_bus   = sreg;
  assign bus.out_count = count_q;

endmodule

// File: tb/tb_scalar_to_bus_packer.sv
// Directed bench for scalar_to_bus_packer: two WIDTH=8 instances (LSB/MSB first)
// and a WIDTH=2 instance share one stimulus stream; unused instances sit in reset.
module tb_scalar_to_bus_packer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic in_valid, in_bit, in_last, out_ready;
  int   sel;
  logic sel_ready;
  int   n_cmp = 0;
  int   n_err = 0;

  scalar_to_bus_packer_if #(.WIDTH(8)) ifa ();
  scalar_to_bus_packer_if #(.WIDTH(8)) ifb ();
  scalar_to_bus_packer_if #(.WIDTH(2)) ifc ();

  assign ifa.in_valid  = in_valid;
  assign ifa.in_bit    = in_bit;
  assign ifa.in_last   = in_last;
  assign ifa.out_ready = out_ready;
  assign ifb.in_valid  = in_valid;
  assign ifb.in_bit    = in_bit;
  assign ifb.in_last   = in_last;
  assign ifb.out_ready = out_ready;
  assign ifc.in_valid  = in_valid;
  assign ifc.in_bit    = in_bit;
  assign ifc.in_last   = in_last;
  assign ifc.out_ready = out_ready;

  scalar_to_bus_packer #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (.clk(clk), .rst_n(rst_a), .bus(ifa.slave));
  scalar_to_bus_packer #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (.clk(clk), .rst_n(rst_b), .bus(ifb.slave));
  scalar_to_bus_packer #(.WIDTH(2), .LSB_FIRST(1'b1)) dut_c (.clk(clk), .rst_n(rst_c), .bus(ifc.slave));

  always_comb begin
    case (sel)
      0:       sel_ready = ifa.in_ready;
      1:       sel_ready = ifb.in_ready;
      default: sel_ready = ifc.in_ready;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Present one bit, wait (bounded) for acceptance, then drop in_valid.
  task automatic send_bit(input logic b, input logic l);
    int waited = 0;
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    @(negedge clk);
    while (!sel_ready && waited < 40) begin
      @(negedge clk);
      waited++;
    end
    if (!sel_ready) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_bit_timeout: in_ready observed 0 expected 1");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Streams w[0] first, w[1] next, ...
  task automatic send_stream(input logic [7:0] w, input int n, input bit with_last);
    for (int i = 0; i < n; i++) send_bit(w[i], with_last && (i == n - 1));
  endtask

  initial begin
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    sel       = 0;
    rst_a     = 1'b0;
    rst_b     = 1'b0;
    rst_c     = 1'b0;

    #12;
    check("rst_out_valid", 32'(ifa.out_valid), 32'h0);
    check("rst_out_bus",   32'(ifa.out_bus),   32'h0);
    check("rst_out_count", 32'(ifa.out_count), 32'h0);
    check("rst_in_ready",  32'(ifa.in_ready),  32'h0);
    check("rst_c_out_valid", 32'(ifc.out_valid), 32'h0);

    @(negedge clk);
    rst_a = 1'b1;
    rst_b = 1'b1;
    #1;
    check("in_ready_before_edge", 32'(ifa.in_ready), 32'h0);
    @(posedge clk);
    #1;
    check("in_ready_after_release", 32'(ifa.in_ready), 32'h1);
    check("in_ready_after_release_b", 32'(ifb.in_ready), 32'h1);

    // Full word 1,0,1,1,0,0,1,0 into both bit orders
    send_stream(8'h4D, 8, 1'b0);
    check("full_out_valid", 32'(ifa.out_valid), 32'h1);
    check("full_lsb_bus",   32'(ifa.out_bus),   32'h4D);
    check("full_lsb_count", 32'(ifa.out_count), 32'd8);
    check("full_in_ready",  32'(ifa.in_ready),  32'h0);
    check("full_msb_valid", 32'(ifb.out_valid), 32'h1);
    check("full_msb_bus",   32'(ifb.out_bus),   32'hB2);
    check("full_msb_count", 32'(ifb.out_count), 32'd8);
    @(posedge clk);
    #1;
    check("full_drain_valid",    32'(ifa.out_valid), 32'h0);
    check("full_drain_in_ready", 32'(ifa.in_ready),  32'h1);
    check("full_msb_drain",      32'(ifb.out_valid), 32'h0);
    rst_b = 1'b0;

    // Early termination and padding
    send_stream(8'h07, 3, 1'b1);
    check("early_valid", 32'(ifa.out_valid), 32'h1);
    check("early_bus",   32'(ifa.out_bus),   32'h07);
    check("early_count", 32'(ifa.out_count), 32'd3);
    @(posedge clk);
    #1;
    send_bit(1'b0, 1'b1);
    check("first_last_bus",   32'(ifa.out_bus),   32'h00);
    check("first_last_count", 32'(ifa.out_count), 32'd1);
    @(posedge clk);
    #1;
    send_bit(1'b1, 1'b1);
    check("first_last1_bus", 32'(ifa.out_bus), 32'h01);
    @(posedge clk);
    #1;
    send_stream(8'h5A, 8, 1'b1);
    check("last_on_8th_bus",   32'(ifa.out_bus),   32'h5A);
    check("last_on_8th_count", 32'(ifa.out_count), 32'd8);
    @(posedge clk);
    #1;

    // Backpressure with the source holding the next bit
    out_ready = 1'b0;
    send_stream(8'hA5, 8, 1'b0);
    check("bp_bus", 32'(ifa.out_bus), 32'hA5);
    in_valid = 1'b1;
    in_bit   = 1'b1;
    in_last  = 1'b1;
    repeat (5) begin
      @(posedge clk);
      #1;
      check("bp_hold_valid",    32'(ifa.out_valid), 32'h1);
      check("bp_hold_bus",      32'(ifa.out_bus),   32'hA5);
      check("bp_hold_count",    32'(ifa.out_count), 32'd8);
      check("bp_hold_in_ready", 32'(ifa.in_ready),  32'h0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_valid",    32'(ifa.out_valid), 32'h0);
    check("bp_release_in_ready", 32'(ifa.in_ready),  32'h1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("bp_held_bit_valid", 32'(ifa.out_valid), 32'h1);
    check("bp_held_bit_bus",   32'(ifa.out_bus),   32'h01);
    check("bp_held_bit_count", 32'(ifa.out_count), 32'd1);
    @(posedge clk);
    #1;
    check("bp_held_drain", 32'(ifa.out_valid), 32'h0);

    // Reset in the middle of a word
    send_stream(8'h0F, 4, 1'b0);
    #2;
    rst_a = 1'b0;
    #1;
    check("midrst_valid",    32'(ifa.out_valid), 32'h0);
    check("midrst_bus",      32'(ifa.out_bus),   32'h0);
    check("midrst_count",    32'(ifa.out_count), 32'h0);
    check("midrst_in_ready", 32'(ifa.in_ready),  32'h0);
    @(negedge clk);
    rst_a = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("midrst_no_emit", 32'(ifa.out_valid), 32'h0);
    send_stream(8'hC3, 8, 1'b0);
    check("midrst_next_bus",   32'(ifa.out_bus),   32'hC3);
    check("midrst_next_count", 32'(ifa.out_count), 32'd8);
    @(posedge clk);
    #1;

    // WIDTH=2 instance
    rst_a = 1'b0;
    sel   = 2;
    @(negedge clk);
    rst_c = 1'b1;
    @(posedge clk);
    #1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    check("w2_full_valid", 32'(ifc.out_valid), 32'h1);
    check("w2_full_bus",   32'(ifc.out_bus),   32'h2);
    check("w2_full_count", 32'(ifc.out_count), 32'd2);
    @(posedge clk);
    #1;
    send_bit(1'b1, 1'b1);
    check("w2_early_bus",   32'(ifc.out_bus),   32'h1);
    check("w2_early_count", 32'(ifc.out_count), 32'd1);
    @(posedge clk);
    #1;
    check("w2_drain", 32'(ifc.out_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/scalar_to_bus_packer.md
Name: scalar_to_bus_packer

Overview:
- Reassembles a stream of single scalar bits into a WIDTH-bit bus word.
- It is the receive-side counterpart of the bus-to-scalar bit splitter, where individual bus bits are driven onto scalar nets.
- Sits between a scalar serial source and any bus consumer; valid/ready handshake on both sides.
- Supports early termination with zero padding and reports the count of valid bits.

Parameters:
- WIDTH, 8, output bus width in bits; legal range ≥ 2.
- LSB_FIRST, 1, 1: first received bit lands in out_bus[0]; 0: first received bit lands in out_bus[WIDTH-1].
- CNT_W, $clog2(WIDTH+1), width of out_count (derived; not overridden).

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  in_bit/in_last are valid this cycle.
- in_ready  output  1  packer accepts a bit this cycle.
- in_bit  input  1  scalar data bit.
- in_last  input  1  this bit closes the word early; pad the rest with zeros.
- out_valid  output  1  out_bus/out_count hold a complete word.
- out_ready  input  1  consumer takes the word this cycle.
- out_bus  output  WIDTH  assembled word.
- out_count  output  CNT_W  number of received bits in out_bus, range 1..WIDTH.

Behaviour:
- Reset: asynchronous on rst_n low. State = FILL, bit index = 0, shift register = 0, out_valid = 0, out_bus = 0, out_count = 0, in_ready = 1 one cycle after release.
- Input transfer: occurs when in_valid and in_ready are both 1 on a rising edge.
- Output transfer: occurs when out_valid and out_ready are both 1 on a rising edge.

States:
- FILL:
  - in_ready = 1, out_valid = 0.
  - On each input transfer, write in_bit at position idx (LSB_FIRST=1) or WIDTH-1-idx (LSB_FIRST=0), then idx++.
  - If the transfer makes idx+1 == WIDTH, or in_last = 1: go to HOLD next cycle, latch out_count = idx+1, and zero unwritten positions.
  - Positions are pre-zeroed when FILL is entered, so no explicit padding pass is needed.
- HOLD:
  - in_ready = 0, out_valid = 1.
  - out_bus and out_count are stable until the output transfer.
  - On the output transfer: next cycle state = FILL, idx = 0, shift register = 0, out_valid = 0.

Latency and throughput:
- Last accepted bit to out_valid: 1 cycle.
- Full-word throughput is one word per WIDTH+1 cycles, because no input is accepted in the HOLD cycle.
- out_ready tied high gives exactly WIDTH+1 cycles per word.

Boundary conditions:
- in_last on the first bit: word with out_count = 1, all other bits 0.
- in_last on the WIDTH-th bit: identical to a normal full word; out_count = WIDTH.
- in_valid while in HOLD: ignored. in_ready = 0, and the source must hold its data (standard valid/ready).
- out_ready high while in FILL: no effect.
- idx wrap: idx never exceeds WIDTH-1; it returns to 0 only through HOLD.
- rst_n asserted mid-word or mid-HOLD: partial word is discarded, out_valid drops immediately (asynchronous), nothing is emitted after release.
- in_bit/in_last are don't-care when in_valid = 0.

Decomposition:
- Shared package scalar_bus_pkg:
  - state enum {FILL, HOLD}.
  - Function to compute the bit position from idx and LSB_FIRST.
  - Constant for the default WIDTH.
- Sub-module: none. Control FSM and shift register stay in one module (~150 lines).
- The bus-to-scalar serializer (the transmitter direction) reuses the same package.

Test Plan:
- Full word, LSB_FIRST=1, WIDTH=8, bits 1,0,1,1,0,0,1,0, out_ready=1 -> out_valid 1 cycle after 8th bit, out_bus=8'h4D, out_count=8, in_ready low for exactly 1 cycle.
- Same bits with LSB_FIRST=0 -> out_bus=8'hB2, out_count=8.
- Early termination, bits 1,1,1 with in_last on 3rd, LSB_FIRST=1 -> out_bus=8'h07, out_count=3; next word starts at idx 0 with cleared register.
- Backpressure: out_ready=0 for 5 cycles after word 8'hA5 completes while source keeps in_valid=1 -> out_bus stable at 8'hA5, in_ready=0 throughout, no input bit lost; next word correct after out_ready=1.
- Reset mid-word: 4 bits accepted, then rst_n pulsed low -> out_valid=0 and out_bus=0 immediately; next 8 bits produce a clean word with out_count=8.
- WIDTH=2 instance, bits 0,1 then 1 with in_last, LSB_FIRST=1 -> words 2'b10 (count 2) then 2'b01 (count 1).
